// File: rtl/pkt_dispatch_seq.sv
// pkt_dispatch_seq: buffers packet headers from upstream in a small FIFO and
// hands them one at a time to the packet filter, then waits until every
// downstream block that owns that packet type has reported completion.
//
// Ports
//   clk, nrst                 clock, synchronous active-low reset
//   in_valid/in_ready         upstream header handshake (push when both high)
//   in_pktType, in_destID     offered header
//   newpkt                    one-cycle issue strobe
//   fPktType, destinationID   header being issued / serviced
//   done_QTU/MNI/KCH/reward   completion pulses from downstream blocks
//   busy                      high while issuing or waiting
//   timeout_cnt               saturating count of packets retired by timeout
//
// Build option: define PKT_DISPATCH_TIMEOUT_EN to retire a packet after
// TIMEOUT WAIT cycles; without it WAIT ends only on completion and
// timeout_cnt is tied to 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | head of FIFO (if any) latched into fPktType/destinationID
// ISSUE | newpkt strobe, pending mask loaded from the packet type
// WAIT  | collecting done pulses; head popped when mask empties

module pkt_dispatch_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_pktType,
  input  logic [15:0] in_destID,
  output logic        newpkt,
  output logic [2:0]  fPktType,
  output logic [15:0] destinationID,
  input  logic        done_QTU,
  input  logic        done_MNI,
  input  logic        done_KCH,
  input  logic        done_reward,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // mask bit order: {reward, KCH, MNI, QTU}
  function automatic logic [3:0] type_mask(input logic [2:0] t);
    case (t)
      3'b000:  type_mask = 4'b1010;
      3'b001:  type_mask = 4'b0110;
      3'b010:  type_mask = 4'b1100;
      3'b011:  type_mask = 4'b0001;
      3'b100:  type_mask = 4'b1010;
      3'b101:  type_mask = 4'b1001;
      3'b110:  type_mask = 4'b1001;
      default: type_mask = 4'b0000;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [18:0]   mem_q [FIFO_DEPTH];
  logic [18:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    fpkt_q, fpkt_d;
  logic [15:0]   dest_q, dest_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    done_vec, mask_left;
  logic          full, push, pop;

`ifdef PKT_DISPATCH_TIMEOUT_EN
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]    tcnt_q, tcnt_d;
`endif

  assign full      = (count_q == DEPTH_C);
  assign push      = in_valid & ~full;
  assign done_vec  = {done_reward, done_KCH, done_MNI, done_QTU};
  assign mask_left = mask_q & ~done_vec;

  // Outputs are forced to their reset values while nrst is low so they are
  // defined even before the first reset edge has been seen.
  assign in_ready      = ~full | ~nrst;
  assign newpkt        = nrst & (state_q == S_ISSUE);
  assign busy          = nrst & ((state_q == S_ISSUE) | (state_q == S_WAIT));
  assign fPktType      = nrst ? fpkt_q : 3'd0;
  assign destinationID = nrst ? dest_q : 16'd0;

`ifdef PKT_DISPATCH_TIMEOUT_EN
  assign timeout_cnt = tcnt_q;
`else
  assign timeout_cnt = 8'd0;
`endif

  always_comb begin
    state_d = state_q;
    fpkt_d  = fpkt_q;
    dest_d  = dest_q;
    mask_d  = mask_q;
    pop     = 1'b0;
`ifdef PKT_DISPATCH_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    tcnt_d     = tcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          {fpkt_d, dest_d} = mem_q[rd_ptr_q];
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mask_d = type_mask(fpkt_q);
        if (type_mask(fpkt_q) == 4'd0) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
`ifdef PKT_DISPATCH_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        mask_d = mask_left;
        // completion wins over an expiry in the same cycle
        if (mask_left == 4'd0) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
`ifdef PKT_DISPATCH_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          pop     = 1'b1;
          state_d = S_IDLE;
          mask_d  = 4'd0;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The head entry stays in the FIFO while it is serviced; it is popped
  // only when the packet retires, so in_ready reflects in-flight work too.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_pktType, in_destID};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fpkt_q   <= 3'd0;
      dest_q   <= 16'd0;
      mask_q   <= 4'd0;
`ifdef PKT_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= 8'd0;
      tcnt_q     <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fpkt_q   <= fpkt_d;
      dest_q   <= dest_d;
      mask_q   <= mask_d;
`ifdef PKT_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      tcnt_q     <= tcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_dispatch_seq.sv
// Testbench for pkt_dispatch_seq: directed stimulus, issued headers checked by
// a scoreboard monitor on every newpkt strobe.
module tb_pkt_dispatch_seq;

`ifdef PKT_DISPATCH_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_pktType = 3'd0;
  logic [15:0] in_destID = 16'd0;
  logic        newpkt;
  logic [2:0]  fPktType;
  logic [15:0] destinationID;
  logic        done_QTU = 1'b0, done_MNI = 1'b0, done_KCH = 1'b0, done_reward = 1'b0;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  pkt_dispatch_seq #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pktType(in_pktType), .in_destID(in_destID), .newpkt(newpkt),
    .fPktType(fPktType), .destinationID(destinationID),
    .done_QTU(done_QTU), .done_MNI(done_MNI), .done_KCH(done_KCH),
    .done_reward(done_reward), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {reward, KCH, MNI, QTU}
  function automatic logic [3:0] mask_of(input logic [2:0] t);
    logic [3:0] m;
    case (t)
      3'd0: m = 4'b1010;
      3'd1: m = 4'b0110;
      3'd2: m = 4'b1100;
      3'd3: m = 4'b0001;
      3'd4: m = 4'b1010;
      3'd5: m = 4'b1001;
      3'd6: m = 4'b1001;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (nrst && newpkt) begin
      if (exp_q.size() == 0) begin
        chk("newpkt_unexpected", 1, 0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("issue_type", int'(fPktType), int'(e[18:16]));
        chk("issue_dest", int'(destinationID), int'(e[15:0]));
      end
    end
  end

  task automatic push(input logic [2:0] t, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pktType = t; in_destID = d;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_accept_timeout", 0, 1);
    else exp_q.push_back({t, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_wait();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !newpkt) && n < 50);
    if (!(busy && !newpkt)) chk("wait_state_timeout", 0, 1);
  endtask

  task automatic wait_newpkt();
    int n = 0;
    do begin @(negedge clk); n++; end while (!newpkt && n < 50);
    if (!newpkt) chk("newpkt_timeout", 0, 1);
  endtask

  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    {done_reward, done_KCH, done_MNI, done_QTU} = v;
    @(posedge clk); #1;
    {done_reward, done_KCH, done_MNI, done_QTU} = 4'b0;
  endtask

  task automatic run_type(input logic [2:0] t, input logic [15:0] d);
    logic [3:0] m, rem;
    int nb;
    push(t, d);
    m = mask_of(t);
    if (m == 4'b0) begin
      nb = 0;
      repeat (20) begin @(negedge clk); if (busy) nb++; end
      chk("busy_cycles_type7", nb, 1);
    end else begin
      wait_wait();
      pulse(~m);
      @(negedge clk);
      chk($sformatf("busy_nonpending_t%0d", t), int'(busy), 1);
      rem = m;
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          if (busy) chk($sformatf("hold_type_t%0d", t), int'(fPktType), int'(t));
          pulse(4'(1 << i));
          rem[i] = 1'b0;
          @(negedge clk);
          chk($sformatf("busy_t%0d_bit%0d", t, i), int'(busy), int'(rem != 4'b0));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_newpkt", int'(newpkt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_type", int'(fPktType), 0);
    chk("rst_dest", int'(destinationID), 0);
    chk("rst_tcnt", int'(timeout_cnt), 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // every type, including 101/0x0007 and the empty-mask 111
    run_type(3'd5, 16'h0007);
    for (int t = 0; t < 8; t++) run_type(3'(t), 16'h1000 + 16'(t));

    // dones during ISSUE are ignored
    push(3'd3, 16'h3333);
    wait_newpkt();
    done_QTU = 1'b1;
    @(posedge clk); #1; done_QTU = 1'b0;
    @(negedge clk);
    chk("issue_done_ignored", int'(busy), 1);
    pulse(4'b0001);
    @(negedge clk);
    chk("issue_done_finish", int'(busy), 0);

    // two dones in one cycle, next packet queued
    push(3'd1, 16'hA001);
    push(3'd3, 16'hA002);
    wait_wait();
    pulse(4'b0110);
    @(negedge clk);
    chk("dual_done_idle", int'(busy), 0);
    chk("dual_done_no_strobe", int'(newpkt), 0);
    @(negedge clk);
    chk("dual_done_next_issue", int'(newpkt), 1);
    wait_wait();
    pulse(4'b0001);
    @(negedge clk);
    chk("dual_done_second", int'(busy), 0);

    // fill the FIFO, hold the 5th header until the first pop
    for (int i = 0; i < 4; i++) push(3'd2, 16'h0100 + 16'(i));
    @(negedge clk);
    chk("full_in_ready", int'(in_ready), 0);
    fork
      push(3'd2, 16'h0104);
      begin
        repeat (3) begin @(negedge clk); chk("held_in_ready", int'(in_ready), 0); end
        pulse(4'b1100);
        @(negedge clk);
        chk("pop_in_ready", int'(in_ready), 1);
      end
    join
    for (int i = 0; i < 4; i++) begin
      wait_wait();
      pulse(4'b1100);
      @(negedge clk);
      chk("drain_busy", int'(busy), 0);
    end

    // no completion: timeout behaviour depends on the build
`ifdef PKT_DISPATCH_TIMEOUT_EN
    begin
      int n;
      push(3'd2, 16'hBEEF);
      wait_newpkt();
      n = 0;
      do begin @(negedge clk); if (busy) n++; end while (busy && n < 50);
      chk("timeout_wait_cycles", n, 10);
      chk("timeout_cnt_1", int'(timeout_cnt), 1);
      push(3'd3, 16'hCAFE);
      wait_newpkt();
      repeat (10) @(negedge clk);
      done_QTU = 1'b1;
      @(posedge clk); #1; done_QTU = 1'b0;
      @(negedge clk);
      chk("expiry_done_idle", int'(busy), 0);
      chk("expiry_done_tcnt", int'(timeout_cnt), 1);
    end
`else
    push(3'd2, 16'hBEEF);
    wait_wait();
    repeat (300) @(negedge clk);
    chk("no_timeout_busy", int'(busy), 1);
    chk("no_timeout_tcnt", int'(timeout_cnt), 0);
    pulse(4'b1100);
    @(negedge clk);
    chk("no_timeout_finish", int'(busy), 0);
`endif

    // reset mid-WAIT with 3 more queued
    for (int i = 0; i < 4; i++) push(3'd2, 16'h0200 + 16'(i));
    wait_wait();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_newpkt", int'(newpkt), 0);
    chk("midrst_type", int'(fPktType), 0);
    chk("midrst_dest", int'(destinationID), 0);
    exp_q.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("postrst_newpkt", int'(newpkt), 0);
      chk("postrst_busy", int'(busy), 0);
    end
    chk("postrst_in_ready", int'(in_ready), 1);
    chk("postrst_tcnt", int'(timeout_cnt), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_dispatch_seq.md
PKT_DISPATCH_SEQ -- requirements
Module: pkt_dispatch_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered packets (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT-state cycles per packet (1..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream packet header valid.
REQ-006 in_ready  output  1  high when FIFO not full; a push occurs when in_valid and in_ready are both high.
REQ-007 in_pktType  input  3  packet type of offered header.
REQ-008 in_destID  input  16  destination ID of offered header.
REQ-009 newpkt  output  1  one-cycle issue strobe to the packet filter.
REQ-010 fPktType  output  3  type of the packet being issued or serviced.
REQ-011 destinationID  output  16  destination ID of the packet being issued or serviced.
REQ-012 done_QTU, done_MNI, done_KCH, done_reward  input  1 each  completion pulses from downstream blocks.
REQ-013 busy  output  1  high in ISSUE and WAIT states.
REQ-014 timeout_cnt  output  8  saturating count of packets retired by timeout.

Function
REQ-015 The FIFO SHALL hold {pktType, destID} entries; in_ready = not full; push and pop in the same cycle SHALL both take effect with count unchanged.
REQ-016 The states SHALL be IDLE, ISSUE and WAIT.
REQ-017 In IDLE with FIFO non-empty, the block SHALL load fPktType/destinationID from the FIFO head and enter ISSUE next cycle; with FIFO empty it SHALL stay in IDLE.
REQ-018 In ISSUE, newpkt SHALL be 1 for exactly that one cycle, and the pending mask SHALL be loaded from fPktType.
REQ-019 Pending mask bits: QTU for types 011/101/110; MNI for 000/001/100; KCH for 001/010; reward for 000/010/100/101/110.
REQ-020 Type 111 (empty mask) SHALL pop the FIFO in ISSUE and return to IDLE without entering WAIT.
REQ-021 In WAIT, each done_* pulse SHALL clear its pending bit; done pulses for non-pending bits SHALL be ignored; done inputs in IDLE and ISSUE SHALL be ignored.
REQ-022 When the pending mask becomes zero, including by multiple dones arriving in the same cycle, the block SHALL pop the FIFO and enter IDLE on that edge.
REQ-023 Minimum spacing between consecutive newpkt strobes SHALL therefore be 3 cycles: ISSUE, WAIT, IDLE.
REQ-024 fPktType and destinationID SHALL hold their values from load until the next load.
REQ-025 New pushes during ISSUE/WAIT SHALL be accepted if not full and SHALL NOT affect the packet being serviced.

Reset
REQ-026 With nrst low at a clock edge, the block SHALL enter IDLE and clear the FIFO pointers and count, the pending mask, the timeout counter and timeout_cnt.
REQ-027 During reset, newpkt, busy, fPktType and destinationID SHALL be 0 and in_ready SHALL be 1.
REQ-028 Reset asserted mid-WAIT SHALL discard the in-flight and all buffered packets.

Configuration
REQ-029 Macro PKT_DISPATCH_TIMEOUT_EN: when defined, a WAIT cycle counter SHALL restart at 0 on WAIT entry; if the mask is still nonzero when it reaches TIMEOUT, the block SHALL pop, increment timeout_cnt (saturating at 255) and enter IDLE.
REQ-030 When PKT_DISPATCH_TIMEOUT_EN is undefined, WAIT SHALL exit only on an empty mask, and timeout_cnt SHALL be constant 0.
REQ-031 A final done arriving in the same cycle as timeout expiry SHALL count as completion, with no timeout_cnt increment.

Verification
REQ-032 Push type 101, dest 0x0007 -> newpkt one cycle later with fPktType=101, destinationID=0x0007; done_QTU then done_reward -> IDLE on the second done.
REQ-033 Push type 001, then assert done_MNI and done_KCH in the same WAIT cycle -> pop and IDLE on that edge, next newpkt 2 cycles later if the FIFO is non-empty.
REQ-034 Push 5 headers back-to-back with FIFO_DEPTH=4 and no dones -> in_ready low after the 4th accepted push, 5th held by upstream; in_ready returns high on the first pop.
REQ-035 Push type 111 -> single newpkt, no WAIT, busy high for exactly 1 cycle.
REQ-036 With PKT_DISPATCH_TIMEOUT_EN defined and TIMEOUT=10, push type 010 and give no dones -> IDLE after 10 WAIT cycles, timeout_cnt=1.
REQ-037 Assert nrst low in WAIT with 3 entries queued -> next cycle IDLE, in_ready=1, no further newpkt without new pushes.
